// File: rtl/conv_mac_engine.sv
// conv_mac_engine: serial KxK multiply-accumulate convolution with optional magnitude and output saturation
module conv_mac_engine #(
    parameter int K      = 3,
    parameter int PIX_W  = 4,
    parameter int COEF_W = 5,
    parameter int ACC_W  = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    mode,
    input  logic [K*K*PIX_W-1:0]    pixels,
    input  logic [K*K*COEF_W-1:0]   filter,
    output logic                    busy,
    output logic                    done,
    output logic [ACC_W-1:0]        conv_out,
    output logic                    sat
);
    localparam int N      = K * K;
    localparam int IDX_W  = $clog2(N);
    localparam int PROD_W = PIX_W + COEF_W + 1;
    localparam int SUM_W  = PROD_W + $clog2(N);
    localparam logic [1:0] S_IDLE = 2'd0, S_MAC = 2'd1, S_DONE = 2'd2;
    localparam logic signed [SUM_W-1:0] MAX_V = SUM_W'((1 << (ACC_W - 1)) - 1);
    localparam logic signed [SUM_W-1:0] MIN_V = ~MAX_V;
    logic [1:0]                 state;
    logic [IDX_W-1:0]           idx;
    logic [N*PIX_W-1:0]         pix_r;
    logic [N*COEF_W-1:0]        coef_r;
    logic                       mode_r;
    logic signed [SUM_W-1:0]    acc;
    logic [PIX_W-1:0]           pix;
    logic [COEF_W-1:0]          coef;
    logic signed [PROD_W-1:0]   prod;
    logic signed [SUM_W-1:0]    mag;
    logic                       clip_hi, clip_lo;
    logic [ACC_W-1:0]           res;
    assign pix     = pix_r[idx*PIX_W +: PIX_W];
    assign coef    = coef_r[idx*COEF_W +: COEF_W];
    assign prod    = $signed({{(COEF_W+1){1'b0}}, pix}) * $signed({{(PIX_W+1){coef[COEF_W-1]}}, coef});
    // acc is wide enough that its negation can never overflow
    assign mag     = (mode_r && acc[SUM_W-1]) ? -acc : acc;
    assign clip_hi = mag > MAX_V;
    assign clip_lo = mag < MIN_V;
    assign res     = clip_hi ? MAX_V[ACC_W-1:0] : clip_lo ? MIN_V[ACC_W-1:0] : mag[ACC_W-1:0];
    assign busy    = state != S_IDLE;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            idx      <= '0;
            pix_r    <= '0;
            coef_r   <= '0;
            mode_r   <= 1'b0;
            acc      <= '0;
            done     <= 1'b0;
            conv_out <= '0;
            sat      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    pix_r  <= pixels;
                    coef_r <= filter;
                    mode_r <= mode;
                    acc    <= '0;
                    idx    <= '0;
                    state  <= S_MAC;
                end
                S_MAC: begin
                    acc <= acc + {{(SUM_W-PROD_W){prod[PROD_W-1]}}, prod};
                    idx <= idx + 1'b1;
                    if (idx == IDX_W'(N - 1)) state <= S_DONE;
                end
                S_DONE: begin
                    conv_out <= res;
                    sat      <= clip_hi | clip_lo;
                    done     <= 1'b1;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_mac_engine.sv
// tb_conv_mac_engine: directed table of windows/kernels plus reset, hold-start and ignored-start sequences
module tb_conv_mac_engine;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [35:0] pixels = '0;
    logic [44:0] filter = '0;
    logic        busy, done, sat;
    logic [9:0]  conv_out;
    int n_vec = 0;
    int n_err = 0;

    conv_mac_engine #(.K(3), .PIX_W(4), .COEF_W(5), .ACC_W(10)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .pixels(pixels), .filter(filter),
        .busy(busy), .done(done), .conv_out(conv_out), .sat(sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mode;
        logic [35:0] pix;
        logic [44:0] coef;
        logic [9:0]  exp;
        logic        exp_sat;
    } vec_t;
    vec_t tbl[10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [35:0] rows(input int t, input int m, input int b);
        logic [35:0] r;
        for (int i = 0; i < 9; i++) r[i*4 +: 4] = 4'(i < 3 ? t : i < 6 ? m : b);
        return r;
    endfunction

    function automatic logic [35:0] pix_tap(input int i, input int v);
        logic [35:0] r = '0;
        r[i*4 +: 4] = 4'(v);
        return r;
    endfunction

    function automatic logic [44:0] coef_all(input int v);
        logic [44:0] r;
        for (int i = 0; i < 9; i++) r[i*5 +: 5] = 5'(v);
        return r;
    endfunction

    function automatic logic [44:0] coef_tap(input int i, input int v);
        logic [44:0] r = '0;
        r[i*5 +: 5] = 5'(v);
        return r;
    endfunction

    function automatic logic [44:0] sobel_y();
        int c[9] = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};
        logic [44:0] r;
        for (int i = 0; i < 9; i++) r[i*5 +: 5] = 5'(c[i]);
        return r;
    endfunction

    // Start one operation, scramble inputs after capture, and return edges from E0 to done.
    task automatic run_op(input logic [35:0] p, input logic [44:0] c, input logic m, input bit noise, output int lat);
        @(negedge clk);
        pixels = p; filter = c; mode = m; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        pixels = 36'({$urandom(), $urandom()});
        filter = 45'({$urandom(), $urandom()});
        mode = ~m;
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) chk("busy_during_op", 64'(busy), 64'd1);
            start = (noise && lat < 5) ? lat[0] : 1'b0;
            pixels = 36'({$urandom(), $urandom()});
            filter = 45'({$urandom(), $urandom()});
        end
        chk("latency", 64'(lat), 64'd10);
        chk("busy_at_done", 64'(busy), 64'd0);
    endtask

    initial begin
        int lat;
        int nd;
        int dcyc[4];
        bit seen;
        tbl[0] = '{1'b0, rows(0, 0, 15), sobel_y(), 10'd60, 1'b0};
        tbl[1] = '{1'b0, rows(15, 0, 0), sobel_y(), 10'h3C4, 1'b0};
        tbl[2] = '{1'b1, rows(15, 0, 0), sobel_y(), 10'd60, 1'b0};
        tbl[3] = '{1'b0, rows(15, 15, 15), coef_all(15), 10'd511, 1'b1};
        tbl[4] = '{1'b0, rows(15, 15, 15), coef_all(-16), 10'h200, 1'b1};
        tbl[5] = '{1'b1, rows(15, 15, 15), coef_all(-16), 10'd511, 1'b1};
        tbl[6] = '{1'b0, rows(15, 15, 15), coef_all(0), 10'd0, 1'b0};
        tbl[7] = '{1'b0, rows(0, 0, 0), coef_all(15), 10'd0, 1'b0};
        tbl[8] = '{1'b0, pix_tap(4, 5), coef_tap(4, -3), 10'h3F1, 1'b0};
        tbl[9] = '{1'b1, pix_tap(4, 5), coef_tap(4, -3), 10'd15, 1'b0};

        #12;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_conv_out", 64'(conv_out), 64'd0);
        chk("reset_sat", 64'(sat), 64'd0);
        @(negedge clk) rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_op(tbl[i].pix, tbl[i].coef, tbl[i].mode, i[0], lat);
            chk($sformatf("vec%0d_conv_out", i), 64'(conv_out), 64'(tbl[i].exp));
            chk($sformatf("vec%0d_sat", i), 64'(sat), 64'(tbl[i].exp_sat));
        end

        // Abort at idx=4 with a non-zero result already held in the outputs.
        @(negedge clk);
        pixels = rows(15, 15, 15); filter = coef_all(15); mode = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_conv_out", 64'(conv_out), 64'd0);
        chk("abort_sat", 64'(sat), 64'd0);
        @(negedge clk) rst = 1'b0;
        seen = 1'b0;
        repeat (15) begin
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        chk("abort_no_done", 64'(seen), 64'd0);
        run_op(rows(0, 0, 15), sobel_y(), 1'b0, 1'b0, lat);
        chk("after_abort_conv_out", 64'(conv_out), 64'd60);

        // Start held high: each accept happens in the IDLE cycle that shows done.
        @(negedge clk);
        pixels = rows(0, 0, 15); filter = sobel_y(); mode = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        nd = 0;
        for (int c = 1; c <= 34; c++) begin
            @(posedge clk); #1;
            if (done) begin
                if (nd < 4) dcyc[nd] = c;
                nd++;
                chk($sformatf("hold_conv_out%0d", nd), 64'(conv_out), 64'd60);
            end
        end
        start = 1'b0;
        chk("hold_done_count", 64'(nd), 64'd3);
        chk("hold_done0", 64'(dcyc[0]), 64'd10);
        chk("hold_done1", 64'(dcyc[1]), 64'd21);
        chk("hold_done2", 64'(dcyc[2]), 64'd32);

        repeat (12) @(posedge clk);
        #1 chk("idle_after_hold", 64'(busy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
